// File: rtl/z80_io_wb_bridge.sv
// z80_io_wb_bridge: turns Z80 I/O read/write cycles into single Wishbone classic cycles for the CPC PPI,
// stretching the CPU with wait_no until the slave acks and holding read data until the strobe ends.
module z80_io_wb_bridge #(
    parameter int SEL_BIT  = 11,
    parameter int SYNC_STG = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] cpu_a_i,
    input  logic [7:0]  cpu_do_i,
    input  logic        iorq_ni,
    input  logic        rd_ni,
    input  logic        wr_ni,
    input  logic        m1_ni,
    output logic [7:0]  cpu_di_o,
    output logic        cpu_di_oe_o,
    output logic        wait_no,
    output logic [1:0]  adr_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    output logic        we_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    output logic        timeout_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

    state_t                   state, state_d;
    logic [SYNC_STG-1:0][3:0] sync_q;
    logic                     iorq_s, rd_s, wr_s, m1_s;
    logic                     act, act_q, hit, unused_a;
    logic [CW-1:0]            cnt, cnt_d;
    logic                     stb_d, wait_d, we_d, oe_d, to_d;
    logic [1:0]               adr_d;
    logic [7:0]               dat_d, di_d;

    assign {iorq_s, rd_s, wr_s, m1_s} = sync_q[SYNC_STG-1];
    assign act      = ~iorq_s & m1_s & (~rd_s | ~wr_s);
    // only a fresh strobe starts a cycle, so one long strobe never retriggers
    assign hit      = act & ~act_q & ~cpu_a_i[SEL_BIT];
    assign cyc_o    = stb_o;
    assign unused_a = ^cpu_a_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '1;
            act_q       <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            stb_o       <= 1'b0;
            wait_no     <= 1'b1;
            adr_o       <= 2'd0;
            dat_o       <= 8'd0;
            we_o        <= 1'b0;
            cpu_di_o    <= 8'hFF;
            cpu_di_oe_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            sync_q[0] <= {iorq_ni, rd_ni, wr_ni, m1_ni};
            for (int i = 1; i < SYNC_STG; i++)
                sync_q[i] <= sync_q[i-1];
            act_q       <= act;
            state       <= state_d;
            cnt         <= cnt_d;
            stb_o       <= stb_d;
            wait_no     <= wait_d;
            adr_o       <= adr_d;
            dat_o       <= dat_d;
            we_o        <= we_d;
            cpu_di_o    <= di_d;
            cpu_di_oe_o <= oe_d;
            timeout_o   <= to_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stb_d   = stb_o;
        wait_d  = wait_no;
        adr_d   = adr_o;
        dat_d   = dat_o;
        we_d    = we_o;
        di_d    = cpu_di_o;
        oe_d    = cpu_di_oe_o;
        to_d    = 1'b0;
        case (state)
            IDLE: if (hit) begin
                adr_d   = cpu_a_i[9:8];
                dat_d   = cpu_do_i;
                we_d    = ~wr_s;
                stb_d   = 1'b1;
                wait_d  = 1'b0;
                cnt_d   = '0;
                state_d = BUS;
            end
            BUS: if (ack_i) begin
                stb_d   = 1'b0;
                wait_d  = 1'b1;
                di_d    = we_o ? cpu_di_o : dat_i;
                oe_d    = ~we_o;
                state_d = HOLD;
            end else if (cnt == LIM) begin
                // abort: reads return open-bus 0xFF so the CPU is never stuck
                stb_d   = 1'b0;
                wait_d  = 1'b1;
                di_d    = 8'hFF;
                oe_d    = ~we_o;
                to_d    = 1'b1;
                state_d = HOLD;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            HOLD: if (!act) begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_z80_io_wb_bridge.sv
// tb_z80_io_wb_bridge: randomized Z80 I/O cycles against a transaction-timeline model of the bridge.
module tb_z80_io_wb_bridge;
    localparam int S  = 2;
    localparam int TO = 16;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic [15:0] cpu_a_i = 16'h0;
    logic [7:0]  cpu_do_i = 8'h0, dat_i = 8'h0;
    logic        iorq_ni = 1'b1, rd_ni = 1'b1, wr_ni = 1'b1, m1_ni = 1'b1, ack_i = 1'b0;
    logic [7:0]  cpu_di_o, dat_o;
    logic        cpu_di_oe_o, wait_no, we_o, stb_o, cyc_o, timeout_o;
    logic [1:0]  adr_o;

    z80_io_wb_bridge #(.SEL_BIT(11), .SYNC_STG(S), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cpu_a_i(cpu_a_i), .cpu_do_i(cpu_do_i),
        .iorq_ni(iorq_ni), .rd_ni(rd_ni), .wr_ni(wr_ni), .m1_ni(m1_ni),
        .cpu_di_o(cpu_di_o), .cpu_di_oe_o(cpu_di_oe_o), .wait_no(wait_no),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // One record per decoded I/O cycle: t = cycle the synchronised strobe is seen,
    // l = cycles stb stays high, r = cycle the CPU releases the strobe.
    typedef struct {
        int t; int l; bit to; bit rd; int r;
        logic [1:0] adr; logic [7:0] dat; bit we; logic [7:0] rdata;
    } rec_t;
    rec_t recs[$];

    int cyc = 0, checks = 0, fails = 0;
    int cur_ackd = 0, scnt = 0;
    logic [7:0] cur_rdata = 8'h0;
    int stb_rises = 0, stb_cycles = 0, wait_low = 0, to_pulses = 0, oe_cycles = 0;
    logic stb_prev = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, a, e);
        end
    endtask

    // Slave: acks in stb cycle cur_ackd (0-based); random spurious acks while idle
    always @(posedge clk_i) begin
        #1;
        if (stb_o) begin
            ack_i = (scnt == cur_ackd);
            dat_i = cur_rdata;
            scnt++;
        end else begin
            ack_i = ($urandom_range(0, 7) == 0);
            dat_i = 8'($urandom);
            scnt = 0;
        end
    end

    always @(negedge clk_i) begin
        int n, hi;
        logic e_stb, e_to, e_oe, e_we;
        logic [1:0] e_adr;
        logic [7:0] e_dat, e_di;
        if (stb_o && !stb_prev) stb_rises++;
        if (stb_o) stb_cycles++;
        if (!wait_no) wait_low++;
        if (timeout_o) to_pulses++;
        if (cpu_di_oe_o) oe_cycles++;
        stb_prev = stb_o;
        n = cyc;
        e_stb = 0; e_to = 0; e_oe = 0; e_we = 0; e_adr = 0; e_dat = 0; e_di = 8'hFF;
        foreach (recs[i]) begin
            if (n >= recs[i].t + 1 && n <= recs[i].t + recs[i].l) e_stb = 1;
            if (recs[i].to && n == recs[i].t + recs[i].l + 1) e_to = 1;
            hi = (recs[i].r + S > recs[i].t + recs[i].l + 1) ? recs[i].r + S : recs[i].t + recs[i].l + 1;
            if (recs[i].rd && n >= recs[i].t + recs[i].l + 1 && n <= hi) e_oe = 1;
            if (n >= recs[i].t + 1) begin
                e_adr = recs[i].adr; e_dat = recs[i].dat; e_we = recs[i].we;
            end
            if (n >= recs[i].t + recs[i].l + 1 && (recs[i].rd || recs[i].to))
                e_di = recs[i].to ? 8'hFF : recs[i].rdata;
        end
        if (!rst_ni) begin
            chk("rst_stb", stb_o, 0); chk("rst_cyc", cyc_o, 0); chk("rst_wait", wait_no, 1);
            chk("rst_oe", cpu_di_oe_o, 0); chk("rst_di", cpu_di_o, 8'hFF); chk("rst_to", timeout_o, 0);
            chk("rst_adr", adr_o, 0); chk("rst_dat", dat_o, 0); chk("rst_we", we_o, 0);
        end else begin
            chk("stb", stb_o, e_stb); chk("cyc", cyc_o, e_stb); chk("wait_n", wait_no, !e_stb);
            chk("timeout", timeout_o, e_to); chk("di_oe", cpu_di_oe_o, e_oe);
            if (e_oe) chk("di", cpu_di_o, e_di);
            chk("adr", adr_o, e_adr); chk("dat", dat_o, e_dat); chk("we", we_o, e_we);
        end
    end

    // extra < 0: strobe dropped early (possibly mid Wishbone cycle)
    task automatic io(input bit wr, input logic [15:0] a, input logic [7:0] d, input bit intack,
                      input int ackd, input logic [7:0] rdat, input int extra, input int gap);
        rec_t rc;
        bit hit;
        int k;
        hit = !intack && !a[11];
        @(posedge clk_i); #2;
        cur_ackd = ackd; cur_rdata = rdat;
        cpu_a_i = a; cpu_do_i = d;
        iorq_ni = 0; m1_ni = !intack; rd_ni = wr; wr_ni = !wr;
        rc.t = cyc + S; rc.l = (ackd < TO) ? ackd + 1 : TO; rc.to = (ackd >= TO);
        rc.rd = !wr; rc.r = 1 << 30; rc.adr = a[9:8]; rc.dat = d; rc.we = wr; rc.rdata = rdat;
        if (hit) recs.push_back(rc);
        if (hit && extra >= 0) begin
            for (k = 0; k < 200; k++) begin
                @(negedge clk_i);
                if (cyc > rc.t && wait_no) break;
            end
            chk("wait_release_bound", k < 200, 1);
            repeat (extra) @(posedge clk_i);
        end else begin
            repeat (extra < 0 ? $urandom_range(0, 1) : extra % 4) @(posedge clk_i);
        end
        @(posedge clk_i); #2;
        iorq_ni = 1; rd_ni = 1; wr_ni = 1; m1_ni = 1;
        if (hit) recs[recs.size() - 1].r = cyc;
        repeat (gap) @(posedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, w, c2, ackl[9];
        int k;
        ackl = '{0, 1, 2, 3, 7, 14, 15, 16, 99};
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1;
        repeat (2) @(posedge clk_i);

        b = stb_rises; w = wait_low;
        io(1, 16'hF712, 8'h82, 0, 1, 8'h00, 0, 2);
        chk("t1_stb_pulses", stb_rises - b, 1); chk("t1_wait_low", wait_low - w, 2);
        chk("t1_adr", adr_o, 3); chk("t1_dat", dat_o, 8'h82); chk("t1_we", we_o, 1);

        b = oe_cycles;
        io(0, 16'hF400, 8'h00, 0, 1, 8'h5A, 3, 4);
        chk("t2_di", cpu_di_o, 8'h5A); chk("t2_oe_cycles", oe_cycles - b, 7);
        chk("t2_oe_after", cpu_di_oe_o, 0); chk("t2_adr", adr_o, 0); chk("t2_we", we_o, 0);

        b = stb_cycles; c2 = to_pulses;
        io(0, 16'hF500, 8'h00, 0, 99, 8'hAA, 0, 2);
        chk("t3_stb_cycles", stb_cycles - b, 16); chk("t3_to_pulses", to_pulses - c2, 1);
        chk("t3_di", cpu_di_o, 8'hFF);

        b = stb_rises; w = wait_low;
        io(0, 16'hF400, 8'h00, 1, 1, 8'h00, 2, 2);
        io(1, 16'hFF00, 8'h11, 0, 1, 8'h00, 2, 2);
        chk("t4_stb_pulses", stb_rises - b, 0); chk("t4_wait_low", wait_low - w, 0);
        chk("t4_oe", cpu_di_oe_o, 0);

        b = stb_rises;
        io(1, 16'hF600, 8'h33, 0, 1, 8'h00, 20, 0);
        chk("t5_first_pulses", stb_rises - b, 1);
        b = stb_rises; w = wait_low;
        io(1, 16'hF700, 8'h44, 0, 2, 8'h00, 0, 3);
        chk("t5_second_pulses", stb_rises - b, 1); chk("t5_wait_low", wait_low - w, 3);
        chk("t5_dat", dat_o, 8'h44);

        @(posedge clk_i); #2;
        cur_ackd = 99; cpu_a_i = 16'hF500; cpu_do_i = 8'h66;
        iorq_ni = 0; wr_ni = 0;
        begin
            rec_t rc;
            rc.t = cyc + S; rc.l = TO; rc.to = 1; rc.rd = 0; rc.r = 1 << 30;
            rc.adr = 2'd1; rc.dat = 8'h66; rc.we = 1; rc.rdata = 8'h00;
            recs.push_back(rc);
        end
        for (k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (stb_o) break;
        end
        chk("t6_stb_seen", stb_o, 1);
        @(posedge clk_i); #2;
        rst_ni = 0; recs.delete();
        iorq_ni = 1; wr_ni = 1;
        #1;
        chk("t6_stb", stb_o, 0); chk("t6_wait", wait_no, 1); chk("t6_oe", cpu_di_oe_o, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1;
        repeat (2) @(posedge clk_i);
        b = stb_rises;
        io(0, 16'hF400, 8'h00, 0, 0, 8'hC3, 1, 3);
        chk("t6_after_pulses", stb_rises - b, 1); chk("t6_after_di", cpu_di_o, 8'hC3);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            bit wr, ia;
            int ex, gp;
            wr = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[11] = 1'b0;
            ia = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                ex = -1; gp = TO + 6;
            end else begin
                ex = $urandom_range(0, 5); gp = $urandom_range(0, 3);
            end
            io(wr, a, 8'($urandom), ia, ackl[$urandom_range(0, 8)], 8'($urandom), ex, gp);
        end
        repeat (4) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
